// File: rtl/heap_array_pkg.sv
// Shared types and address helper for the heap-array engine.
package heap_array_pkg;

  typedef enum logic [2:0] {
    OP_ALLOC  = 3'd0,
    OP_FREE   = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_SIZE   = 3'd4,
    OP_INSERT = 3'd5
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Flat heap address, formed at 32 bits so callers truncate only once.
  function automatic int unsigned heap_addr(input int unsigned array,
                                            input int unsigned index,
                                            input int unsigned narea);
    return array * narea + index;
  endfunction

endpackage

// File: rtl/heap_ram.sv
// Heap storage: one synchronous write port, one combinational read port.
module heap_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/heap_array_unit.sv
// Heap-array command engine: alloc/free/write/read/size/insert with
// bounds and double-free checking.
//
// state | meaning
// IDLE  | accepting commands; single-cycle ops complete here
// SHIFT | insert in progress, moving one element up per cycle
module heap_array_unit
  import heap_array_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int NARRAYS = 16,
  parameter int NAREA   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_array,
  input  logic [WIDTH-1:0] cmd_index,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic [WIDTH-1:0] in_use
);

  localparam int DEPTH = NARRAYS * NAREA;
  localparam int HAW   = $clog2(DEPTH);
  localparam int AIW   = $clog2(NARRAYS);
  localparam int SPW   = $clog2(NARRAYS + 1);
  localparam logic [WIDTH-1:0] NARR_W  = WIDTH'(NARRAYS);
  localparam logic [WIDTH-1:0] NAREA_W = WIDTH'(NAREA);
  localparam logic [SPW-1:0]   NARR_S  = SPW'(NARRAYS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] size_q  [NARRAYS];
  logic [WIDTH-1:0] size_d  [NARRAYS];
  logic [AIW-1:0]   stack_q [NARRAYS];
  logic [AIW-1:0]   stack_d [NARRAYS];
  logic [NARRAYS-1:0] used_q, used_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   allocs_q, allocs_d;
  logic [WIDTH-1:0] in_use_q, in_use_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [AIW-1:0]   ins_arr_q, ins_arr_d;
  logic [WIDTH-1:0] ins_idx_q, ins_idx_d;
  logic [WIDTH-1:0] ins_data_q, ins_data_d;

  logic             ram_we;
  logic [HAW-1:0]   ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  logic [AIW-1:0]   arr, alloc_id;
  logic             arr_ok, idx_ok, cur_used, err;
  logic [WIDTH-1:0] cur_size;
  logic [HAW-1:0]   cmd_addr, ins_src, ins_dst, sh_src, sh_dst, ins_pos;

  assign arr      = cmd_array[AIW-1:0];
  assign arr_ok   = cmd_array < NARR_W;
  assign idx_ok   = cmd_index < NAREA_W;
  assign cur_size = size_q[arr];
  assign cur_used = used_q[arr];

  assign cmd_addr = HAW'(heap_addr(32'(cmd_array), 32'(cmd_index), NAREA));
  assign ins_src  = HAW'(heap_addr(32'(cmd_array), 32'(cur_size) - 1, NAREA));
  assign ins_dst  = HAW'(heap_addr(32'(cmd_array), 32'(cur_size), NAREA));
  assign sh_src   = HAW'(heap_addr(32'(ins_arr_q), 32'(ptr_q) - 1, NAREA));
  assign sh_dst   = HAW'(heap_addr(32'(ins_arr_q), 32'(ptr_q), NAREA));
  assign ins_pos  = HAW'(heap_addr(32'(ins_arr_q), 32'(ins_idx_q), NAREA));

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign in_use    = in_use_q;

  heap_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(HAW)) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Read address kept apart from the main decode so the shift's
  // read-modify-write does not form a combinational loop.
  always_comb begin
    if (state_q == SHIFT)          ram_raddr = sh_src;
    else if (cmd_op == OP_INSERT)  ram_raddr = ins_src;
    else                           ram_raddr = cmd_addr;
  end

  // Command decode, error checks and next-state for all bookkeeping.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    stack_d     = stack_q;
    used_d      = used_q;
    sp_d        = sp_q;
    allocs_d    = allocs_q;
    in_use_d    = in_use_q;
    ptr_d       = ptr_q;
    ins_arr_d   = ins_arr_q;
    ins_idx_d   = ins_idx_q;
    ins_data_d  = ins_data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = cmd_addr;
    ram_wdata   = cmd_data;
    alloc_id    = '0;
    err         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rsp_valid_d = 1'b1;
          case (cmd_op)
            OP_ALLOC: begin
              if (!arr_ok) begin
                err = 1'b1;
              end else if (sp_q != '0) begin
                alloc_id = stack_q[AIW'(sp_q - 1'b1)];
                sp_d     = sp_q - 1'b1;
              end else if (allocs_q < NARR_S) begin
                alloc_id = allocs_q[AIW-1:0];
                allocs_d = allocs_q + 1'b1;
              end else begin
                err = 1'b1;
              end
              if (!err) begin
                size_d[alloc_id] = '0;
                used_d[alloc_id] = 1'b1;
                in_use_d         = in_use_q + 1'b1;
                rsp_data_d       = WIDTH'(alloc_id);
              end
            end
            OP_FREE: begin
              if (!arr_ok || !cur_used) begin
                err = 1'b1;
              end else begin
                stack_d[AIW'(sp_q)] = arr;
                sp_d                = sp_q + 1'b1;
                used_d[arr]         = 1'b0;
                in_use_d            = in_use_q - 1'b1;
              end
            end
            OP_WRITE: begin
              if (!arr_ok || !cur_used || !idx_ok) begin
                err = 1'b1;
              end else begin
                ram_we = 1'b1;
                if (cmd_index >= cur_size) size_d[arr] = cmd_index + 1'b1;
              end
            end
            OP_READ: begin
              if (!arr_ok || !cur_used || !idx_ok || cmd_index >= cur_size) err = 1'b1;
              else rsp_data_d = ram_rdata;
            end
            OP_SIZE: begin
              if (!arr_ok || !cur_used) err = 1'b1;
              else rsp_data_d = cur_size;
            end
            OP_INSERT: begin
              if (!arr_ok || !cur_used || !idx_ok || cur_size == NAREA_W ||
                  cmd_index > cur_size) begin
                err = 1'b1;
              end else if (cmd_index == cur_size) begin
                ram_we      = 1'b1;
                size_d[arr] = cur_size + 1'b1;
              end else begin
                // First (highest) element moves on the accepting edge.
                ram_we      = 1'b1;
                ram_waddr   = ins_dst;
                ram_wdata   = ram_rdata;
                ptr_d       = cur_size - 1'b1;
                ins_arr_d   = arr;
                ins_idx_d   = cmd_index;
                ins_data_d  = cmd_data;
                state_d     = SHIFT;
                rsp_valid_d = 1'b0;
              end
            end
            default: err = 1'b1;
          endcase
          rsp_error_d = err;
          if (err) rsp_data_d = '0;
        end
      end
      SHIFT: begin
        ram_we = 1'b1;
        if (ptr_q != ins_idx_q) begin
          ram_waddr = sh_dst;
          ram_wdata = ram_rdata;
          ptr_d     = ptr_q - 1'b1;
        end else begin
          ram_waddr          = ins_pos;
          ram_wdata          = ins_data_q;
          size_d[ins_arr_q]  = size_q[ins_arr_q] + 1'b1;
          rsp_valid_d        = 1'b1;
          state_d            = IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset of all bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= '{default: '0};
      stack_q     <= '{default: '0};
      used_q      <= '0;
      sp_q        <= '0;
      allocs_q    <= '0;
      in_use_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      ptr_q       <= '0;
      ins_arr_q   <= '0;
      ins_idx_q   <= '0;
      ins_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      stack_q     <= stack_d;
      used_q      <= used_d;
      sp_q        <= sp_d;
      allocs_q    <= allocs_d;
      in_use_q    <= in_use_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      ptr_q       <= ptr_d;
      ins_arr_q   <= ins_arr_d;
      ins_idx_q   <= ins_idx_d;
      ins_data_q  <= ins_data_d;
    end
  end

endmodule

// File: tb/tb_heap_array_unit.sv
// Directed self-checking bench for heap_array_unit (NARRAYS=4, NAREA=4).
module tb_heap_array_unit;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_array = '0;
  logic [W-1:0] cmd_index = '0;
  logic [W-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_error;
  logic [W-1:0] in_use;

  int vectors = 0;
  int miscompares = 0;

  heap_array_unit #(.WIDTH(W), .NARRAYS(4), .NAREA(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_array (cmd_array),
    .cmd_index (cmd_index),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .in_use    (in_use)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command from a negedge; return the response seen at later
  // negedges, the number of cycles until it (1 = next cycle) and how many
  // of those cycles had cmd_ready low.
  task automatic send(input logic [2:0] op, input logic [W-1:0] arr,
                      input logic [W-1:0] idx, input logic [W-1:0] dat,
                      output logic v, output logic e, output logic [W-1:0] d,
                      output int lat, output int low);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_array = arr; cmd_index = idx; cmd_data = dat;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    v = 1'b0; e = 1'b0; d = '0; lat = 0; low = 0;
    while (!v && lat < 20) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) begin
        v = 1'b1; e = rsp_error; d = rsp_data;
      end else if (!cmd_ready) begin
        low++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({cmd_ready, rsp_valid, rsp_error, rsp_data, in_use} !== {3'b000, 12'd0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%0b v=%0b e=%0b d=%0d in_use=%0d want all 0",
               cmd_ready, rsp_valid, rsp_error, rsp_data, in_use);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b want 1", cmd_ready);
    end
  endtask

  task automatic test_alloc();
    logic v, e; logic [W-1:0] d; int lat, low;
    for (int i = 0; i < 3; i++) begin
      send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
      vectors++;
      if ({v, e, d, lat} !== {1'b1, 1'b0, W'(i), 32'd1}) begin
        miscompares++;
        $display("FAIL alloc_%0d: got v=%0b e=%0b id=%0d lat=%0d want v=1 e=0 id=%0d lat=1",
                 i, v, e, d, lat, i);
      end
    end
    vectors++;
    if (in_use !== 12'd3) begin
      miscompares++;
      $display("FAIL alloc_in_use: got %0d want 3", in_use);
    end
    @(negedge clock);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_pulse: got rsp_valid=%0b want 0", rsp_valid);
    end
    send(3'd1, 12'd1, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, in_use} !== {1'b1, 1'b0, 12'd2}) begin
      miscompares++;
      $display("FAIL free_1: got v=%0b e=%0b in_use=%0d want v=1 e=0 in_use=2", v, e, in_use);
    end
    send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b0, 12'd1}) begin
      miscompares++;
      $display("FAIL realloc_1: got v=%0b e=%0b id=%0d want id=1", v, e, d);
    end
    send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, in_use} !== {1'b1, 1'b0, 12'd3, 12'd4}) begin
      miscompares++;
      $display("FAIL alloc_3: got e=%0b id=%0d in_use=%0d want e=0 id=3 in_use=4", e, d, in_use);
    end
    send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, in_use} !== {1'b1, 1'b1, 12'd0, 12'd4}) begin
      miscompares++;
      $display("FAIL alloc_exhausted: got v=%0b e=%0b d=%0d in_use=%0d want v=1 e=1 d=0 in_use=4",
               v, e, d, in_use);
    end
  endtask

  task automatic test_write_read();
    logic v, e; logic [W-1:0] d; int lat, low;
    send(3'd2, 12'd0, 12'd2, 12'd3, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, lat} !== {1'b1, 1'b0, 12'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL write_idx2: got v=%0b e=%0b d=%0d lat=%0d want 1 0 0 1", v, e, d, lat);
    end
    send(3'd4, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b0, 12'd3}) begin
      miscompares++;
      $display("FAIL size_after_write: got e=%0b size=%0d want e=0 size=3", e, d);
    end
    send(3'd3, 12'd0, 12'd2, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b0, 12'd3}) begin
      miscompares++;
      $display("FAIL read_idx2: got e=%0b data=%0d want e=0 data=3", e, d);
    end
    send(3'd3, 12'd0, 12'd3, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b1, 12'd0}) begin
      miscompares++;
      $display("FAIL read_past_size: got v=%0b e=%0b d=%0d want 1 1 0", v, e, d);
    end
    send(3'd2, 12'd0, 12'd4, 12'd7, v, e, d, lat, low);
    vectors++;
    if ({v, e} !== {1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL write_idx4: got v=%0b e=%0b want 1 1", v, e);
    end
    send(3'd4, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({e, d} !== {1'b0, 12'd3}) begin
      miscompares++;
      $display("FAIL size_after_bad_write: got e=%0b size=%0d want 0 3", e, d);
    end
  endtask

  task automatic test_insert();
    logic v, e; logic [W-1:0] d; int lat, low;
    logic [W-1:0] init_vals [3];
    logic [W-1:0] want [4];
    init_vals = '{12'd10, 12'd20, 12'd30};
    want = '{12'd5, 12'd10, 12'd20, 12'd30};
    for (int i = 0; i < 3; i++) send(3'd2, 12'd0, W'(i), init_vals[i], v, e, d, lat, low);
    send(3'd5, 12'd0, 12'd0, 12'd5, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, lat, low} !== {1'b1, 1'b0, 12'd0, 32'd4, 32'd3}) begin
      miscompares++;
      $display("FAIL insert_shift: got v=%0b e=%0b d=%0d lat=%0d ready_low=%0d want 1 0 0 4 3",
               v, e, d, lat, low);
    end
    for (int i = 0; i < 4; i++) begin
      send(3'd3, 12'd0, W'(i), 12'd0, v, e, d, lat, low);
      vectors++;
      if ({v, e, d} !== {1'b1, 1'b0, want[i]}) begin
        miscompares++;
        $display("FAIL insert_read_%0d: got e=%0b data=%0d want e=0 data=%0d", i, e, d, want[i]);
      end
    end
    send(3'd4, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({e, d} !== {1'b0, 12'd4}) begin
      miscompares++;
      $display("FAIL insert_size: got e=%0b size=%0d want 0 4", e, d);
    end
    send(3'd5, 12'd0, 12'd1, 12'd6, v, e, d, lat, low);
    vectors++;
    if ({v, e, lat, low} !== {1'b1, 1'b1, 32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL insert_full: got v=%0b e=%0b lat=%0d ready_low=%0d want 1 1 1 0", v, e, lat, low);
    end
    send(3'd5, 12'd1, 12'd0, 12'd7, v, e, d, lat, low);
    vectors++;
    if ({v, e, lat, low} !== {1'b1, 1'b0, 32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL insert_append: got v=%0b e=%0b lat=%0d ready_low=%0d want 1 0 1 0", v, e, lat, low);
    end
    send(3'd3, 12'd1, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({e, d} !== {1'b0, 12'd7}) begin
      miscompares++;
      $display("FAIL append_read: got e=%0b data=%0d want 0 7", e, d);
    end
    send(3'd5, 12'd1, 12'd2, 12'd9, v, e, d, lat, low);
    vectors++;
    if ({v, e} !== {1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL insert_gap: got v=%0b e=%0b want 1 1", v, e);
    end
  endtask

  task automatic test_free();
    logic v, e; logic [W-1:0] d; int lat, low;
    send(3'd1, 12'd2, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, in_use} !== {1'b1, 1'b0, 12'd3}) begin
      miscompares++;
      $display("FAIL free_2: got v=%0b e=%0b in_use=%0d want 1 0 3", v, e, in_use);
    end
    send(3'd1, 12'd2, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, in_use} !== {1'b1, 1'b1, 12'd3}) begin
      miscompares++;
      $display("FAIL double_free: got v=%0b e=%0b in_use=%0d want 1 1 3", v, e, in_use);
    end
    send(3'd3, 12'd2, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e} !== {1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL read_freed: got v=%0b e=%0b want 1 1", v, e);
    end
  endtask

  task automatic test_back_to_back();
    logic v, e; logic [W-1:0] d; int lat, low;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_array = 12'd3; cmd_index = '0; cmd_data = '0;
    @(posedge clock);
    #1 cmd_op = 3'd0; cmd_array = 12'd0;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, rsp_error, cmd_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL b2b_free: got v=%0b e=%0b ready=%0b want 1 0 1", rsp_valid, rsp_error, cmd_ready);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 12'd3}) begin
      miscompares++;
      $display("FAIL b2b_alloc: got v=%0b e=%0b id=%0d want 1 0 3", rsp_valid, rsp_error, rsp_data);
    end
    send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, in_use} !== {1'b1, 1'b0, 12'd2, 12'd4}) begin
      miscompares++;
      $display("FAIL lifo_alloc: got e=%0b id=%0d in_use=%0d want 0 2 4", e, d, in_use);
    end
  endtask

  task automatic test_errors();
    logic v, e; logic [W-1:0] d; int lat, low;
    send(3'd6, 12'd0, 12'd0, 12'd1, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, lat} !== {1'b1, 1'b1, 12'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL reserved_op: got v=%0b e=%0b d=%0d lat=%0d want 1 1 0 1", v, e, d, lat);
    end
    send(3'd3, 12'd4, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d, lat} !== {1'b1, 1'b1, 12'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL array_range: got v=%0b e=%0b d=%0d lat=%0d want 1 1 0 1", v, e, d, lat);
    end
    send(3'd4, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({e, d, in_use} !== {1'b0, 12'd4, 12'd4}) begin
      miscompares++;
      $display("FAIL errors_no_effect: got e=%0b size=%0d in_use=%0d want 0 4 4", e, d, in_use);
    end
  endtask

  task automatic test_reset_shift();
    logic v, e; logic [W-1:0] d; int lat, low;
    send(3'd2, 12'd1, 12'd1, 12'd8, v, e, d, lat, low);
    send(3'd2, 12'd1, 12'd2, 12'd9, v, e, d, lat, low);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_array = 12'd1; cmd_index = 12'd0; cmd_data = 12'd4;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL shift_busy: got ready=%0b v=%0b want 0 0", cmd_ready, rsp_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, in_use} !== {1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_in_shift: got v=%0b in_use=%0d want 0 0", rsp_valid, in_use);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL after_shift_reset: got v=%0b ready=%0b want 0 1", rsp_valid, cmd_ready);
    end
    send(3'd0, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL fresh_alloc: got v=%0b e=%0b id=%0d want 1 0 0", v, e, d);
    end
    send(3'd4, 12'd0, 12'd0, 12'd0, v, e, d, lat, low);
    vectors++;
    if ({v, e, d} !== {1'b1, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL fresh_size: got v=%0b e=%0b size=%0d want 1 0 0", v, e, d);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_write_read();
    test_insert();
    test_free();
    test_back_to_back();
    test_errors();
    test_reset_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/heap_array_unit.md
# heap_array_unit

Parametrised heap-array engine for the BTree FPGA test harness. It owns heap memory, per-array sizes, the allocation counter and the freed-array stack, and executes one array command at a time: alloc, free, write, read, size and insert-with-shift. Generated test programs issue commands through a valid/ready port instead of inlining heap arithmetic in every instruction. Unlike the fixed inline version, this block adds bounds and double-free checking and a multi-cycle element shift for insert.

## Interface
Parameters:
- WIDTH, 12, memory element, array id and index width
- NARRAYS, 16, maximum number of arrays; heap depth is NARRAYS*NAREA
- NAREA, 4, elements per array area

Ports (`clock` and `reset`):
- clock  in  1  driving clock; one clock, all state on its rising edge
- reset  in  1  synchronous, active-high; restarts the block
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  0 ALLOC, 1 FREE, 2 WRITE, 3 READ, 4 SIZE, 5 INSERT; 6–7 reserved
- cmd_array  in  WIDTH  target array id
- cmd_index  in  WIDTH  element index
- cmd_data  in  WIDTH  write/insert data
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  WIDTH  ALLOC: array id; READ: element; SIZE: length; otherwise 0
- rsp_error  out  1  qualifies rsp_valid; command had no effect
- in_use  out  WIDTH  count of currently allocated arrays

## Operation
- Handshake: command accepted on a rising edge where cmd_valid && cmd_ready. No response backpressure; the consumer must sample rsp_valid.
- State machine: IDLE, SHIFT, with cmd_ready = (state==IDLE) && !reset.
- ALLOC:
  - If the freed stack is non-empty, pop it (LIFO).
  - Else if allocs < NARRAYS, return allocs and increment allocs.
  - Else error.
  - On success, size[id] is cleared to 0, the in-use bit is set and in_use is incremented. Heap contents are not cleared.
- FREE: array must be in use, otherwise error. Push the id, clear the in-use bit and decrement in_use. The stack depth is NARRAYS, so it cannot overflow.
- WRITE: heap[array*NAREA+index] = data; size[array] = max(size, index+1).
- READ: returns heap[array*NAREA+index]. Index >= size is an error.
- SIZE: returns size[array].
- INSERT (index <= size < NAREA):
  - Move elements size-1 down to index up by one, one element per cycle, highest first, in SHIFT.
  - Then write data at index and increment size.
  - index == size needs no shift and behaves as an append.
- Common errors, checked before any state change:
  - array >= NARRAYS;
  - array not in use (except ALLOC);
  - index >= NAREA (WRITE, READ, INSERT);
  - INSERT with size == NAREA or index > size;
  - reserved opcode.
- Arithmetic: address = array*NAREA + index, computed at full width before truncation to the heap address width. Sizes saturate at NAREA by construction.

## Timing
- Reset values: cmd_ready 0 while reset is high and 1 from the first cycle after; rsp_valid 0, rsp_data 0, rsp_error 0, in_use 0. allocs, stack top, all in-use bits and all sizes are 0.
- Single-cycle ops: accepted at edge T, response visible after edge T+1 with a 1-cycle latency. Back-to-back commands are accepted every cycle.
- INSERT: k = size−index shift cycles; the response is at T+1+k and cmd_ready is low for k cycles. For k == 0 the response is at T+1.
- Errors follow the same latency as the op, with no shift cycles.
- Reset mid-SHIFT: abandons the shift and returns to IDLE with no response. Heap contents are undefined; all bookkeeping is cleared.
- FREE then ALLOC on consecutive cycles: the ALLOC sees the pushed id.

## Structure
- Package heap_array_pkg:
  - op_t enum (ALLOC..INSERT);
  - state_t enum (IDLE, SHIFT);
  - function heap_addr(array, index, NAREA).
- Sub-module heap_ram: WIDTH × NARRAYS*NAREA, one synchronous write port and one combinational read port.
  - The shift reads address a−1 and writes a in the same cycle.
- Top level holds the sizes, in-use bitmap, freed stack, allocs and FSM.

## Test plan
- After reset: ALLOC ×3 -> rsp_data 0,1,2, in_use 3. FREE 1, then ALLOC -> 1. ALLOC with NARRAYS=4 exhausted (ids 0–3 in use) -> rsp_error 1, in_use unchanged.
- WRITE arr0 idx2=3, then SIZE -> 3. READ idx2 -> 3. READ idx3 -> error. WRITE idx4 with NAREA=4 -> error.
- Array 0 holds [10,20,30], size 3. INSERT idx0 data 5 -> cmd_ready low 3 cycles, response at T+4, contents [5,10,20,30], SIZE 4. A further INSERT -> error.
- FREE 2 twice -> second response rsp_error 1. READ on the freed array -> error.
- Reset asserted during the second SHIFT cycle -> no rsp_valid; SIZE 0 after a fresh ALLOC returns 0.
- Opcode 6 and cmd_array=NARRAYS -> rsp_error 1, rsp_data 0, one-cycle latency, no state change.
